// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the pipeline register chain.
//   WIDTH_DEF / STAGES_DEF  default bundle width and stage count
//   IF_ID .. MEM_WB         stage indices of the classic five-stage datapath
//   cnt_w()                 bits needed to hold a count of 0..n
//   sat_add16()             16-bit add that sticks at 16'hFFFF
package pipe_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;

    localparam int IF_ID  = 0;
    localparam int ID_EX  = 1;
    localparam int EX_MEM = 2;
    localparam int MEM_WB = 3;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register (valid bit plus WIDTH-bit bundle).
//   clk, reset    clock and synchronous active-high reset
//   load          take load_valid / load_data this cycle
//   load_valid    valid bit to load; 0 inserts a bubble
//   load_data     bundle to load (only captured with a valid bit)
//   clear         squash: drop the valid bit, wins over load
//   valid, data   current stage contents
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clear,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A bubble keeps the old data; only the valid bit drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= load_valid;
            if (load_valid) begin
                data_q <= load_data;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: chain of STAGES pipeline registers with per-stage valid bits,
// load-use stall (freeze young stages, bubble into stage HOLD_DEPTH), branch
// flush (squash stages below FLUSH_DEPTH) and valid/ready at both ends.
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data  upstream handshake into stage 0
//   stall, flush               hazard hold / branch squash
//   out_valid/out_ready/out_data  oldest stage to the writeback consumer
//   stage_valid, stage_data    every stage exposed (stage i at [i*WIDTH +: WIDTH])
//   occupancy                  registered count of valid stages
//   stall_cycles, squash_count saturating event counters
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int STAGES      = STAGES_DEF,
    parameter int HOLD_DEPTH  = 1,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*WIDTH-1:0]    stage_data,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [15:0]                stall_cycles,
    output logic [15:0]                squash_count
);

    localparam int OCC_W = cnt_w(STAGES);

    logic              stall_eff;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [WIDTH-1:0]  d [STAGES];

    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [15:0]       stall_q, stall_d;
    logic [15:0]       squash_q, squash_d;
    logic [15:0]       squash_pop;

    // Flush overrides stall entirely.
    assign stall_eff = stall && !flush;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam bit FREEZE    = (g < HOLD_DEPTH);
        localparam bit BUB_STALL = (g == HOLD_DEPTH);
        localparam bit BUB_FLUSH = (g == FLUSH_DEPTH);
        localparam bit SQUASH    = (g < FLUSH_DEPTH);

        logic             older_open;
        logic             open_s;
        logic             up_valid;
        logic             load_valid;
        logic             clr;
        logic [WIDTH-1:0] up_data;

        if (g == STAGES-1) begin : g_oldest
            assign older_open = out_ready;
        end else begin : g_inner
            assign older_open = g_stage[g+1].open_s;
        end

        if (g == 0) begin : g_youngest
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_follow
            assign up_valid = v[g-1];
            assign up_data  = d[g-1];
        end

        // A stage can take new contents when it is empty or its occupant moves on.
        assign open_s = (!v[g] || older_open) && !(FREEZE && stall_eff);

        // The stage just above a frozen or squashed region receives a bubble.
        assign load_valid = up_valid
                            && !(BUB_STALL && stall_eff)
                            && !(BUB_FLUSH && flush);

        assign clr = SQUASH && flush;

        assign v_next[g] = clr ? 1'b0 : (open_s ? load_valid : v[g]);

        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clk        (clk),
            .reset      (reset),
            .load       (open_s),
            .load_valid (load_valid),
            .load_data  (up_data),
            .clear      (clr),
            .valid      (v[g]),
            .data       (d[g])
        );

        assign stage_data[g*WIDTH +: WIDTH] = d[g];
    end

    assign in_ready    = g_stage[0].open_s && !flush;
    assign stage_valid = v;
    assign out_valid   = v[STAGES-1];
    assign out_data    = d[STAGES-1];

    always_comb begin
        logic [STAGES-1:0] vs;
        squash_pop = '0;
        vs         = v;
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
            squash_pop = squash_pop + {15'd0, vs[0]};
            vs         = vs >> 1;
        end

        occ_d = '0;
        vs    = v_next;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + {{(OCC_W-1){1'b0}}, vs[0]};
            vs    = vs >> 1;
        end

        stall_d  = stall_eff ? sat_add16(stall_q, 16'd1) : stall_q;
        squash_d = flush ? sat_add16(squash_q, squash_pop) : squash_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q    <= '0;
            stall_q  <= '0;
            squash_q <= '0;
        end else begin
            occ_q    <= occ_d;
            stall_q  <= stall_d;
            squash_q <= squash_d;
        end
    end

    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;
    assign squash_count = squash_q;

endmodule
